// File: rtl/uart_mmio_bridge_if.sv
// CPU external-device request/response bus as seen by the UART MMIO bridge.
// The CPU drives the request side; the bridge drives the response side.
interface uart_mmio_bridge_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_done;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata,
        input  rsp_rdata, rsp_done, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata,
        output rsp_rdata, rsp_done, rsp_err
    );
endinterface

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped responder between the CPU external-device port and the UART.
// Stores to TXDATA are sent LSB byte first to the transmitter; received bytes
// are buffered in an RX FIFO and returned by loads from RXDATA.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for req_valid; decodes and latches the request
//   S_TX_SEND | issue tx_start for the next byte once tx_ready is high
//   S_TX_WAIT | one dead cycle so the transmitter can drop tx_ready
//   S_RX_POP  | pop one FIFO byte per cycle into rdata; stalls while empty
//   S_DONE    | one-cycle rsp_done pulse, then back to S_IDLE
//
// Register map (only addr[3:0] decoded): 0x0 TXDATA (W), 0x4 RXDATA (R),
// 0x8 STATUS (R) = {count, ovf, tx_ready} in bits [9:0].
module uart_mmio_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_AW    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    uart_mmio_bridge_if.slave bus,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_ready,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid
);

    localparam int              DEPTH  = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] L_FULL = DEPTH[FIFO_AW:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_SEND,
        S_TX_WAIT,
        S_RX_POP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Request latches / datapath
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [2:0]            r_cnt;
    logic [1:0]            r_idx;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    // RX FIFO
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;

    // Decode / control
    logic [3:0]            w_off;
    logic                  w_is_tx;
    logic                  w_is_rx;
    logic                  w_is_st;
    logic                  w_misalign;
    logic                  w_err;
    logic [2:0]            w_nbytes;
    logic [DATA_WIDTH-1:0] w_size_mask;
    logic [DATA_WIDTH-1:0] w_status;
    logic                  w_accept;
    logic                  w_status_rd;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [7:0]            w_rd_byte;
    logic                  w_unused_addr;

    // Upper address bits are not decoded; the register block aliases through them.
    assign w_unused_addr = ^bus.req_addr[ADDR_WIDTH-1:4];

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == L_FULL);
    assign w_rd_byte    = r_mem[r_rd_ptr];

    assign w_status = {{(DATA_WIDTH-10){1'b0}}, 8'(r_count), r_ovf, i_tx_ready};

    // Address/size decode of the pending request
    always_comb begin
        w_off       = bus.req_addr[3:0];
        w_is_tx     = (w_off == 4'h0);
        w_is_rx     = (w_off == 4'h4);
        w_is_st     = (w_off == 4'h8);
        w_nbytes    = 3'd1;
        w_size_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
        w_misalign  = 1'b0;
        case (bus.req_size)
            2'd1: begin
                w_nbytes    = 3'd2;
                w_size_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
                w_misalign  = w_off[0];
            end
            2'd2: begin
                w_nbytes    = 3'd4;
                w_size_mask = '1;
                w_misalign  = (w_off[1:0] != 2'b00);
            end
            default: ;
        endcase
        w_err = (bus.req_size == 2'd3) || w_misalign
             || !(w_is_tx || w_is_rx || w_is_st)
             || (bus.req_we && !w_is_tx)
             || (!bus.req_we && w_is_tx);
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and strobes
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_pop        = 1'b0;
        o_tx_start   = 1'b0;
        o_tx_data    = 8'h00;
        bus.rsp_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (w_err) begin
                        w_next = S_DONE;
                    end else if (bus.req_we) begin
                        w_next = S_TX_SEND;
                    end else if (w_is_rx) begin
                        w_next = S_RX_POP;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_TX_SEND: begin
                if (i_tx_ready) begin
                    o_tx_start = 1'b1;
                    o_tx_data  = r_shreg[7:0];
                    w_next     = (r_cnt == 3'd1) ? S_DONE : S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                w_next = S_TX_SEND;
            end
            S_RX_POP: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (r_cnt == 3'd1) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                bus.rsp_done = 1'b1;
                w_next       = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_status_rd = w_accept && !w_err && !bus.req_we && w_is_st;
    assign w_push      = i_rx_valid && (!w_fifo_full || w_pop);
    assign w_drop      = i_rx_valid && w_fifo_full && !w_pop;

    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    // Request latch, TX shift register and RX byte assembly
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_err   <= w_err;
            r_cnt   <= w_nbytes;
            r_idx   <= '0;
            r_rdata <= w_status_rd ? (w_status & w_size_mask) : '0;
            if (!w_err && bus.req_we) begin
                r_shreg <= bus.req_wdata;
            end
        end else if (o_tx_start) begin
            r_shreg <= {8'h00, r_shreg[DATA_WIDTH-1:8]};
            r_cnt   <= r_cnt - 3'd1;
        end else if (w_pop) begin
            r_rdata[{r_idx, 3'b000} +: 8] <= w_rd_byte;
            r_idx <= r_idx + 2'd1;
            r_cnt <= r_cnt - 3'd1;
        end
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_rx_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // A drop in the same cycle as a STATUS read wins so it is not lost.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_status_rd) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: vector table of single requests
// plus directed sequences for TX serialisation, blocking RX, FIFO overflow
// and reset in the middle of a transmit.
module tb_uart_mmio_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_mmio_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready_model = 1'b1;
    logic       tx_ready_en = 1'b1;

    assign tx_ready = tx_ready_model & tx_ready_en;

    uart_mmio_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .FIFO_AW(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .i_tx_ready (tx_ready),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid)
    );

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: logs each byte, drops ready the cycle after tx_start
    logic [7:0]  tx_log [$];
    int unsigned tx_cyc [$];
    always begin
        @(negedge clk);
        if (tx_start) begin
            tx_log.push_back(tx_data);
            tx_cyc.push_back(cyc);
            @(posedge clk);
            #1 tx_ready_model = 1'b0;
            repeat (3) @(posedge clk);
            #1 tx_ready_model = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic cpu_req(input logic we, input logic [15:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat, output int unsigned done_cyc);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        rdata = 32'h0;
        err = 1'b0;
        done_cyc = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_done) break;
        end
        if (!bus.rsp_done) begin
            checks++;
            failures++;
            $display("FAIL rsp_done_timeout actual=none required=rsp_done within 200 cycles");
        end else begin
            rdata = bus.rsp_rdata;
            err = bus.rsp_err;
            done_cyc = cyc;
            @(negedge clk);
            check("done_one_cycle", 32'(bus.rsp_done), 32'h0);
        end
    endtask

    task automatic push_after(input int n, input logic [7:0] b);
        repeat (n) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int unsigned dc;
        int unsigned push_cyc;
        int          starts;
        int          guard;
        logic [31:0] drain_exp [4];

        // STATUS values assume A5,5A buffered (count 2) and an idle transmitter
        vecs[0]  = '{"st_cnt2",     1'b0, 16'h0008, 2'd2, 32'h0,        32'h0000_0009, 1'b0, 1};
        vecs[1]  = '{"ld_0xC",      1'b0, 16'h000C, 2'd2, 32'h0,        32'h0,         1'b1, 1};
        vecs[2]  = '{"ld_w_0x2",    1'b0, 16'h0002, 2'd2, 32'h0,        32'h0,         1'b1, 1};
        vecs[3]  = '{"ld_size3",    1'b0, 16'h0004, 2'd3, 32'h0,        32'h0,         1'b1, 1};
        vecs[4]  = '{"st_rxdata",   1'b1, 16'h0004, 2'd2, 32'hDEADBEEF, 32'h0,         1'b1, 1};
        vecs[5]  = '{"ld_txdata",   1'b0, 16'h0000, 2'd2, 32'h0,        32'h0,         1'b1, 1};
        vecs[6]  = '{"st_status",   1'b1, 16'h0008, 2'd2, 32'h12345678, 32'h0,         1'b1, 1};
        vecs[7]  = '{"ld_b_0x5",    1'b0, 16'h0005, 2'd0, 32'h0,        32'h0,         1'b1, 1};
        vecs[8]  = '{"ld_h_0x6",    1'b0, 16'h0006, 2'd1, 32'h0,        32'h0,         1'b1, 1};
        vecs[9]  = '{"st_b_0x1",    1'b1, 16'h0001, 2'd0, 32'h000000AA, 32'h0,         1'b1, 1};
        vecs[10] = '{"st_size3",    1'b1, 16'h0000, 2'd3, 32'h000000BB, 32'h0,         1'b1, 1};
        vecs[11] = '{"st_h_0x2",    1'b1, 16'h0002, 2'd1, 32'h0000CCCC, 32'h0,         1'b1, 1};
        vecs[12] = '{"st_alias",    1'b0, 16'hFF08, 2'd2, 32'h0,        32'h0000_0009, 1'b0, 1};
        vecs[13] = '{"st_byte",     1'b0, 16'h0008, 2'd0, 32'h0,        32'h0000_0009, 1'b0, 1};
        vecs[14] = '{"ld_half_rx",  1'b0, 16'h0004, 2'd1, 32'h0,        32'h0000_5AA5, 1'b0, 3};
        vecs[15] = '{"st_empty",    1'b0, 16'h0008, 2'd2, 32'h0,        32'h0000_0001, 1'b0, 1};

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_size  = 2'd0;
        bus.req_wdata = 32'h0;
        rx_valid      = 1'b0;
        rx_data       = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_rsp_done", 32'(bus.rsp_done), 32'h0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        push_after(1, 8'hA5);
        push_after(1, 8'h5A);

        foreach (vecs[i]) begin
            cpu_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, er, lat, dc);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
        end
        check("err_no_tx", 32'(tx_log.size()), 32'h0);

        // Word store: bytes 11,22,33,44, done the cycle after the 4th tx_start
        tx_log.delete();
        tx_cyc.delete();
        cpu_req(1'b1, 16'h0000, 2'd2, 32'h44332211, rd, er, lat, dc);
        check("txw_err", 32'(er), 32'h0);
        check("txw_nbytes", 32'(tx_log.size()), 32'd4);
        if (tx_log.size() == 4) begin
            check("txw_b0", 32'(tx_log[0]), 32'h11);
            check("txw_b1", 32'(tx_log[1]), 32'h22);
            check("txw_b2", 32'(tx_log[2]), 32'h33);
            check("txw_b3", 32'(tx_log[3]), 32'h44);
            check("txw_done_cyc", dc, tx_cyc[3] + 1);
        end

        tx_log.delete();
        tx_cyc.delete();
        cpu_req(1'b1, 16'h0000, 2'd0, 32'hFFFFFFA7, rd, er, lat, dc);
        check("txb_err", 32'(er), 32'h0);
        check("txb_nbytes", 32'(tx_log.size()), 32'd1);
        if (tx_log.size() == 1) check("txb_b0", 32'(tx_log[0]), 32'hA7);

        tx_log.delete();
        tx_cyc.delete();
        cpu_req(1'b1, 16'h0000, 2'd1, 32'h1234BEEF, rd, er, lat, dc);
        check("txh_nbytes", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() == 2) begin
            check("txh_b0", 32'(tx_log[0]), 32'hEF);
            check("txh_b1", 32'(tx_log[1]), 32'hBE);
        end

        // Byte load from empty FIFO blocks until 0x7E arrives 20 cycles later
        push_cyc = 0;
        fork
            cpu_req(1'b0, 16'h0004, 2'd0, 32'h0, rd, er, lat, dc);
            begin
                repeat (20) @(negedge clk);
                push_cyc = cyc;
                rx_valid = 1'b1;
                rx_data  = 8'h7E;
                @(negedge clk);
                rx_valid = 1'b0;
            end
        join
        check("rxblk_rdata", rd, 32'h0000_007E);
        check("rxblk_err", 32'(er), 32'h0);
        check("rxblk_done_cyc", dc, push_cyc + 2);
        repeat (3) @(negedge clk);
        check("rdata_held", bus.rsp_rdata, 32'h0000_007E);

        // Overflow: 17 pushes into depth 16 with the transmitter busy
        tx_ready_en = 1'b0;
        for (int i = 0; i < 17; i++) push_after(1, 8'(8'h80 + i));
        fork
            cpu_req(1'b0, 16'h0008, 2'd2, 32'h0, rd, er, lat, dc);
            push_after(1, 8'h91);
        join
        check("ovf_st1", rd, 32'h0000_0042);
        cpu_req(1'b0, 16'h0008, 2'd2, 32'h0, rd, er, lat, dc);
        check("ovf_st2_sticky", rd, 32'h0000_0042);
        cpu_req(1'b0, 16'h0008, 2'd2, 32'h0, rd, er, lat, dc);
        check("ovf_st3_clear", rd, 32'h0000_0040);

        // Push into a full FIFO in the same cycle as a pop
        fork
            cpu_req(1'b0, 16'h0004, 2'd0, 32'h0, rd, er, lat, dc);
            push_after(2, 8'hEE);
        join
        check("fullpop_rdata", rd, 32'h0000_0080);
        check("fullpop_lat", 32'(lat), 32'd2);
        cpu_req(1'b0, 16'h0008, 2'd2, 32'h0, rd, er, lat, dc);
        check("fullpop_st", rd, 32'h0000_0040);

        drain_exp[0] = 32'h84838281;
        drain_exp[1] = 32'h88878685;
        drain_exp[2] = 32'h8C8B8A89;
        drain_exp[3] = 32'hEE8F8E8D;
        for (int i = 0; i < 4; i++) begin
            cpu_req(1'b0, 16'h0004, 2'd2, 32'h0, rd, er, lat, dc);
            check($sformatf("drain%0d_rdata", i), rd, drain_exp[i]);
            check($sformatf("drain%0d_lat", i), 32'(lat), 32'd5);
        end
        cpu_req(1'b0, 16'h0008, 2'd2, 32'h0, rd, er, lat, dc);
        check("drain_st", rd, 32'h0000_0000);

        // Reset asserted during a tx_start cycle of a word store
        tx_ready_en = 1'b1;
        push_after(1, 8'h33);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0000;
        bus.req_size  = 2'd2;
        bus.req_wdata = 32'h55667788;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        starts = 0;
        guard = 0;
        while (starts < 2 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (tx_start) starts++;
        end
        if (starts < 2) begin
            checks++;
            failures++;
            $display("FAIL rstmid_wait actual=%0d starts required=2", starts);
        end
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_tx_start", 32'(tx_start), 32'h0);
        check("rstmid_tx_data", 32'(tx_data), 32'h0);
        check("rstmid_rsp_done", 32'(bus.rsp_done), 32'h0);
        check("rstmid_rsp_err", 32'(bus.rsp_err), 32'h0);
        check("rstmid_rsp_rdata", bus.rsp_rdata, 32'h0);
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tx_log.delete();
        cpu_req(1'b0, 16'h0008, 2'd2, 32'h0, rd, er, lat, dc);
        check("post_rst_status", rd, 32'h0000_0001);
        check("post_rst_lat", 32'(lat), 32'd1);
        check("post_rst_no_tx", 32'(tx_log.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
